alu_serial_exec: RTL

//   Execute-stage consumer of the 4-bit ALU control code from the ALU control decoder.

---
 rtl/alu_serial_exec.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_serial_exec.sv
// Digit-serial execute-stage ALU (AND/OR/ADD/SUB/SLT) with valid/ready on both sides.
// Optional signed-overflow output enabled by defining ALU_OVERFLOW_EN.
module alu_serial_exec #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
`ifdef ALU_OVERFLOW_EN
  ,
  output logic            overflow
`endif
);

  localparam int unsigned N    = XLEN / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
  typedef enum logic [2:0] {OpAnd, OpOr, OpAdd, OpSub, OpSlt, OpIll} op_e;

  state_e          state_q;
  op_e             op_q, acc_op;
  logic [XLEN-1:0] a_q, b_q, res_q;
  logic [CntW-1:0] cnt_q;
  logic            carry_q, nz_q, zero_q, illegal_q;
  logic            in_ready_q, out_valid_q;
`ifdef ALU_OVERFLOW_EN
  logic            ovf_q;
`endif

  logic [DIGIT-1:0] a_dig, b_dig, b_eff, dig_res;
  logic [DIGIT:0]   sum;
  logic             sub_op, dig_ovf, slt_bit, last;

  always_comb begin
    unique case (alu_ctrl)
      4'b0000: acc_op = OpAnd;
      4'b0001: acc_op = OpOr;
      4'b0010: acc_op = OpAdd;
      4'b0110: acc_op = OpSub;
      4'b0111: acc_op = OpSlt;
      default: acc_op = OpIll;
    endcase
  end

  // Operands are shifted right each cycle, so the current digit is always the low digit.
  always_comb begin
    a_dig   = a_q[DIGIT-1:0];
    b_dig   = b_q[DIGIT-1:0];
    sub_op  = (op_q == OpSub) || (op_q == OpSlt);
    b_eff   = sub_op ? ~b_dig : b_dig;
    sum     = {1'b0, a_dig} + {1'b0, b_eff} + (DIGIT + 1)'(carry_q);
    // Only meaningful on the top digit: signed overflow of the full-width sum.
    dig_ovf = (a_dig[DIGIT-1] == b_eff[DIGIT-1]) && (sum[DIGIT-1] != a_dig[DIGIT-1]);
    slt_bit = sum[DIGIT-1] ^ dig_ovf;
    last    = (cnt_q == CntLast);
    dig_res = '0;
    unique case (op_q)
      OpAnd:               dig_res = a_dig & b_dig;
      OpOr:                dig_res = a_dig | b_dig;
      OpAdd, OpSub, OpSlt: dig_res = sum[DIGIT-1:0];
      default:             dig_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= OpAnd;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      nz_q        <= 1'b0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q    <= StBusy;
            op_q       <= acc_op;
            a_q        <= op_a;
            b_q        <= op_b;
            res_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= (acc_op == OpSub) || (acc_op == OpSlt);
            nz_q       <= 1'b0;
            zero_q     <= 1'b0;
            illegal_q  <= 1'b0;
            in_ready_q <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            ovf_q      <= 1'b0;
`endif
          end
        end
        StBusy: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= sum[DIGIT];
          nz_q    <= nz_q | (|dig_res);
          if (last) begin
            state_q     <= StDone;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            illegal_q   <= (op_q == OpIll);
            if (op_q == OpSlt) begin
              res_q  <= XLEN'(slt_bit);
              zero_q <= ~slt_bit;
            end else begin
              res_q  <= {dig_res, res_q[XLEN-1:DIGIT]};
              zero_q <= ~(nz_q | (|dig_res));
            end
`ifdef ALU_OVERFLOW_EN
            ovf_q <= ((op_q == OpAdd) || (op_q == OpSub)) && dig_ovf;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
            res_q <= {dig_res, res_q[XLEN-1:DIGIT]};
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
`ifdef ALU_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule
